tracer_dump_ctrl: RTL and testbench

Sequencer for the trace logger: programs the post-trigger count and trigger value over a Wishbone master port, arms the logger, watches the trigger bus for the hit, waits out the post-trigger window, then reads the full capture back and streams it out 32 bits at a time over a valid/ready port. It sits between the host command source (e.g. a UART/JTAG bridge) and the trace logger's Wishbone slave port. The host never has to poll or address the logger directly.

---
 rtl/tracer_dump_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_tracer_dump_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tracer_dump_ctrl.sv
// tracer_dump_ctrl: programs the trace logger over Wishbone, arms it,
// waits for the trigger hit plus the post-trigger window, then streams
// the whole capture out 32 bits at a time on a valid/ready port.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   start_i, abort_i          run control (abort wins over start)
//   trig_val_i, post_cnt_i    run settings, sampled on start_i
//   trig_i                    trigger bus shared with the logger
//   wbm_*                     Wishbone master towards the logger
//   dump_data_o/valid/ready   capture stream out
//   busy_o, done_o            run status
//   trig_seen_o               trigger observed in this run
//
// Parameters: DATA_WIDTH (multiple of 32), POST_SLACK.
// Define TRACER_DUMP_HEADER_EN to prefix the stream with two
// header words (magic | DATA_WORDS, then post_cnt).
module tracer_dump_ctrl #(
    parameter int DATA_WIDTH = 96,
    parameter int POST_SLACK = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] trig_val_i,
    input  logic [9:0]  post_cnt_i,
    input  logic [31:0] trig_i,
    output logic [21:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [31:0] dump_data_o,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        trig_seen_o
);

    localparam int DATA_WORDS = DATA_WIDTH / 32;
    localparam logic [11:0] LAST_W = 12'(DATA_WORDS);

`ifdef TRACER_DUMP_HEADER_EN
    localparam logic [31:0] HDR_MAGIC = 32'h7EAC_E000 | 32'(DATA_WORDS);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_ARM, S_SETTLE, S_WAIT_TRIG,
        S_WAIT_POST, S_HDR, S_RD, S_PUSH, S_DONE
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_ARM, S_SETTLE, S_WAIT_TRIG,
        S_WAIT_POST, S_RD, S_PUSH, S_DONE
    } state_t;
`endif

    state_t      state;
    logic [31:0] trig_val;
    logic [9:0]  post_cnt;
    logic [10:0] post_timer;
    logic        settle_cnt;
    logic [9:0]  idx;
    logic [11:0] w;
`ifdef TRACER_DUMP_HEADER_EN
    logic        hdr_sel;
`endif

    assign wbm_sel_o = 4'hF;
    assign busy_o    = (state != S_IDLE) && (state != S_DONE);
    assign done_o    = (state == S_DONE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= S_IDLE;
            trig_val     <= '0;
            post_cnt     <= '0;
            post_timer   <= '0;
            settle_cnt   <= 1'b0;
            idx          <= '0;
            w            <= '0;
`ifdef TRACER_DUMP_HEADER_EN
            hdr_sel      <= 1'b0;
`endif
            wbm_adr_o    <= '0;
            wbm_dat_o    <= '0;
            wbm_we_o     <= 1'b0;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            dump_data_o  <= '0;
            dump_valid_o <= 1'b0;
            trig_seen_o  <= 1'b0;
        end else if (abort_i) begin
            // In-flight bus cycle and pending stream word are dropped.
            state        <= S_IDLE;
            wbm_we_o     <= 1'b0;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            dump_valid_o <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        trig_val    <= trig_val_i;
                        post_cnt    <= post_cnt_i;
                        trig_seen_o <= 1'b0;
                        state       <= S_CFG;
                    end
                end
                // Each bus state issues on its first cycle (cyc low) and
                // leaves on ack, so cyc is low for one cycle in between.
                S_CFG: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_adr_o <= 22'd4;
                        wbm_dat_o <= {22'b0, post_cnt};
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_adr_o <= 22'd0;
                        wbm_dat_o <= trig_val;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        wbm_we_o   <= 1'b0;
                        settle_cnt <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end
                // Logger needs two cycles to re-arm; ignore matches here.
                S_SETTLE: begin
                    if (settle_cnt) settle_cnt <= 1'b0;
                    else            state      <= S_WAIT_TRIG;
                end
                S_WAIT_TRIG: begin
                    if (trig_i == trig_val) begin
                        trig_seen_o <= 1'b1;
                        post_timer  <= {1'b0, post_cnt} + 11'(POST_SLACK);
                        state       <= S_WAIT_POST;
                    end
                end
                S_WAIT_POST: begin
                    if (post_timer == '0) begin
                        idx <= '0;
                        w   <= '0;
`ifdef TRACER_DUMP_HEADER_EN
                        hdr_sel      <= 1'b0;
                        dump_data_o  <= HDR_MAGIC;
                        dump_valid_o <= 1'b1;
                        state        <= S_HDR;
`else
                        state <= S_RD;
`endif
                    end else begin
                        post_timer <= post_timer - 11'd1;
                    end
                end
`ifdef TRACER_DUMP_HEADER_EN
                S_HDR: begin
                    if (dump_ready_i) begin
                        if (!hdr_sel) begin
                            hdr_sel     <= 1'b1;
                            dump_data_o <= {22'b0, post_cnt};
                        end else begin
                            dump_valid_o <= 1'b0;
                            state        <= S_RD;
                        end
                    end
                end
`endif
                S_RD: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_adr_o <= {w, idx};
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o    <= 1'b0;
                        wbm_stb_o    <= 1'b0;
                        dump_data_o  <= wbm_dat_i;
                        dump_valid_o <= 1'b1;
                        state        <= S_PUSH;
                    end
                end
                // Entry-major walk: all words of one entry, then next.
                S_PUSH: begin
                    if (dump_ready_i) begin
                        dump_valid_o <= 1'b0;
                        if (w == LAST_W) begin
                            w <= '0;
                            if (idx == 10'd1023) begin
                                state <= S_DONE;
                            end else begin
                                idx   <= idx + 10'd1;
                                state <= S_RD;
                            end
                        end else begin
                            w     <= w + 12'd1;
                            state <= S_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tracer_dump_ctrl.sv
// tb_tracer_dump_ctrl: randomized self-checking bench for
// tracer_dump_ctrl with a small Wishbone logger model.
module tb_tracer_dump_ctrl;

    localparam int DW    = 96 / 32;
    localparam int SLACK = 4;
    localparam int NREAD = 1024 * (DW + 1);
`ifdef TRACER_DUMP_HEADER_EN
    localparam int NHDR  = 2;
`else
    localparam int NHDR  = 0;
`endif
    localparam int NSTREAM = NREAD + NHDR;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] trig_val_i = '0;
    logic [9:0]  post_cnt_i = '0;
    logic [31:0] trig_i = '0;
    logic [21:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic [31:0] dump_data_o;
    logic        dump_valid_o;
    logic        dump_ready_i = 1'b0;
    logic        busy_o, done_o, trig_seen_o;

    int asserts = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tracer_dump_ctrl #(.DATA_WIDTH(96), .POST_SLACK(SLACK)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .start_i(start_i), .abort_i(abort_i),
        .trig_val_i(trig_val_i), .post_cnt_i(post_cnt_i),
        .trig_i(trig_i),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .dump_data_o(dump_data_o), .dump_valid_o(dump_valid_o),
        .dump_ready_i(dump_ready_i),
        .busy_o(busy_o), .done_o(done_o), .trig_seen_o(trig_seen_o)
    );

    // Logger capture contents, a fixed function of the word address.
    function automatic logic [31:0] mem(input logic [21:0] a);
        logic [31:0] x;
        x = {10'b0, a} * 32'h9E37_79B1;
        return x ^ 32'h00C0_FFEE;
    endfunction

    // Logger slave: acks one cycle after stb, every other cycle if held.
    always @(posedge clk) begin
        if (rst) wbm_ack_i <= 1'b0;
        else     wbm_ack_i <= wbm_cyc_o & wbm_stb_o & ~wbm_ack_i;
    end
    assign wbm_dat_i = mem(wbm_adr_o);

    function automatic logic [21:0] rd_addr(input int n);
        int idx, w;
        idx = n / (DW + 1);
        w   = n % (DW + 1);
        return 22'((w << 10) | idx);
    endfunction

    function automatic logic [31:0] exp_word(input int n,
                                             input logic [9:0] pc);
        if (NHDR == 2 && n == 0) return 32'h7EAC_E000 | 32'(DW);
        if (NHDR == 2 && n == 1) return {22'b0, pc};
        return mem(rd_addr(n - NHDR));
    endfunction

    task automatic pulse_start(input logic [31:0] tv,
                               input logic [9:0] pc);
        @(negedge clk);
        start_i    = 1'b1;
        trig_val_i = tv;
        post_cnt_i = pc;
        @(negedge clk);
        start_i    = 1'b0;
        trig_val_i = $urandom;
        post_cnt_i = 10'($urandom);
    endtask

    // Full run from start to DONE, checking bus writes, read order,
    // trigger latency and every stream word against the model.
    task automatic run_capture(input logic [31:0] tv, input logic [9:0] pc,
                               input int stall_pct, input int trig_at);
        int n = 1, wr_n = 0, rd_n = 0, acc_n = 0, trig_n = 0;
        bit first_rd = 1'b1;
        bit hold = 1'b0;
        logic [31:0] hold_data = '0;
        trig_i = ~tv;
        pulse_start(tv, pc);
        asserts++;
        if (busy_o !== 1'b1 || wbm_stb_o !== 1'b0) begin
            fails++;
            $display("FAIL start_state busy=%b stb=%b want 1/0",
                     busy_o, wbm_stb_o);
        end
        while (done_o !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                asserts++;
                if (wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1) begin
                    fails++;
                    $display("FAIL cfg_stb_latency stb=%b we=%b want 1/1",
                             wbm_stb_o, wbm_we_o);
                end
            end
            if (n == trig_at) begin
                asserts++;
                if (trig_seen_o !== 1'b0) begin
                    fails++;
                    $display("FAIL trig_seen_early got %b want 0",
                             trig_seen_o);
                end
                trig_i = tv;
                trig_n = n;
            end
            if (wbm_cyc_o && wbm_stb_o && !wbm_we_o && first_rd) begin
                first_rd = 1'b0;
                asserts++;
                if (trig_n == 0 || n - trig_n < int'(pc) + SLACK ||
                    n - trig_n > int'(pc) + SLACK + NHDR + 8 ||
                    trig_seen_o !== 1'b1) begin
                    fails++;
                    $display("FAIL first_read_latency got %0d seen=%b want %0d..%0d seen=1",
                             n - trig_n, trig_seen_o, int'(pc) + SLACK,
                             int'(pc) + SLACK + NHDR + 8);
                end
            end
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                asserts++;
                if (wbm_we_o) begin
                    if (wr_n == 0 && (wbm_adr_o !== 22'd4 ||
                        wbm_dat_o !== {22'b0, pc})) begin
                        fails++;
                        $display("FAIL cfg_write adr=%h dat=%h want 4/%h",
                                 wbm_adr_o, wbm_dat_o, pc);
                    end else if (wr_n == 1 && (wbm_adr_o !== 22'd0 ||
                                 wbm_dat_o !== tv)) begin
                        fails++;
                        $display("FAIL arm_write adr=%h dat=%h want 0/%h",
                                 wbm_adr_o, wbm_dat_o, tv);
                    end else if (wr_n > 1) begin
                        fails++;
                        $display("FAIL extra_write adr=%h", wbm_adr_o);
                    end
                    wr_n++;
                end else begin
                    if (wbm_adr_o !== rd_addr(rd_n) ||
                        wbm_sel_o !== 4'hF) begin
                        fails++;
                        $display("FAIL read_addr #%0d got %h sel %h want %h sel f",
                                 rd_n, wbm_adr_o, wbm_sel_o, rd_addr(rd_n));
                    end
                    rd_n++;
                end
            end
            if (hold) begin
                asserts++;
                if (dump_valid_o !== 1'b1 || dump_data_o !== hold_data) begin
                    fails++;
                    $display("FAIL stall_stable valid=%b data=%h want 1/%h",
                             dump_valid_o, dump_data_o, hold_data);
                end
            end
            dump_ready_i = ($urandom_range(99) >= stall_pct);
            if (dump_valid_o && dump_ready_i) begin
                asserts++;
                if (acc_n >= NSTREAM ||
                    dump_data_o !== exp_word(acc_n, pc)) begin
                    fails++;
                    $display("FAIL stream_word #%0d got %h want %h",
                             acc_n, dump_data_o, exp_word(acc_n, pc));
                end
                acc_n++;
            end
            hold      = dump_valid_o && !dump_ready_i;
            hold_data = dump_data_o;
        end
        dump_ready_i = 1'b0;
        asserts++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL run_done done=%b busy=%b want 1/0 (timeout?)",
                     done_o, busy_o);
        end
        asserts++;
        if (acc_n != NSTREAM || rd_n != NREAD || wr_n != 2) begin
            fails++;
            $display("FAIL run_counts words=%0d reads=%0d writes=%0d want %0d/%0d/2",
                     acc_n, rd_n, wr_n, NSTREAM, NREAD);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        asserts++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 ||
            wbm_we_o !== 1'b0 || wbm_adr_o !== '0 || wbm_dat_o !== '0) begin
            fails++;
            $display("FAIL reset_bus cyc=%b stb=%b we=%b adr=%h dat=%h want zeros",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o);
        end
        asserts++;
        if (wbm_sel_o !== 4'hF) begin
            fails++;
            $display("FAIL reset_sel got %h want f", wbm_sel_o);
        end
        asserts++;
        if (dump_valid_o !== 1'b0 || dump_data_o !== '0 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || trig_seen_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_status v=%b d=%h busy=%b done=%b seen=%b want zeros",
                     dump_valid_o, dump_data_o, busy_o, done_o, trig_seen_o);
        end
    endtask

    task automatic test_main_run();
        run_capture(32'h0000_00A5, 10'd32, 0, 100);
    endtask

    // Match only while the logger re-arms, then a mismatch forever.
    task automatic test_settle_ignore();
        logic [31:0] tv = $urandom;
        int k = 0;
        trig_i = ~tv;
        pulse_start(tv, 10'($urandom_range(1, 60)));
        asserts++;
        if (trig_seen_o !== 1'b0) begin
            fails++;
            $display("FAIL seen_cleared_on_start got %b want 0", trig_seen_o);
        end
        while (!(wbm_ack_i && wbm_we_o && wbm_adr_o == 22'd0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        asserts++;
        if (k >= 50) begin
            fails++;
            $display("FAIL arm_write_timeout got none want ack within 50");
        end
        trig_i = tv;
        @(negedge clk);
        @(negedge clk);
        trig_i = ~tv;
        repeat (40) @(negedge clk);
        asserts++;
        if (trig_seen_o !== 1'b0 || busy_o !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            fails++;
            $display("FAIL settle_ignore seen=%b busy=%b cyc=%b want 0/1/0",
                     trig_seen_o, busy_o, wbm_cyc_o);
        end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        asserts++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL settle_abort busy=%b done=%b want 0/0",
                     busy_o, done_o);
        end
    endtask

    // Abort with a read strobe outstanding, start held too, then a
    // fresh run with 30% sink stalls.
    task automatic test_abort_restart();
        logic [31:0] tv = $urandom;
        int k = 0;
        trig_i = ~tv;
        pulse_start(tv, 10'($urandom_range(0, 20)));
        repeat (20) @(negedge clk);
        trig_i = tv;
        while (!(wbm_cyc_o && wbm_stb_o && !wbm_we_o) && k < 200) begin
            @(negedge clk);
            k++;
        end
        asserts++;
        if (k >= 200) begin
            fails++;
            $display("FAIL read_timeout got none want read within 200");
        end
        abort_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        start_i = 1'b0;
        asserts++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 ||
            busy_o !== 1'b0 || dump_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_drop cyc=%b stb=%b busy=%b valid=%b want 0000",
                     wbm_cyc_o, wbm_stb_o, busy_o, dump_valid_o);
        end
        repeat (3) @(negedge clk);
        asserts++;
        if (busy_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle busy=%b cyc=%b want 0/0",
                     busy_o, wbm_cyc_o);
        end
        run_capture($urandom, 10'($urandom_range(0, 200)), 30,
                    $urandom_range(30, 80));
    endtask

    initial begin
        test_reset();
        test_main_run();
        test_settle_ignore();
        test_abort_restart();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
